// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM-style pipeline issue logic.
//   inflight_t  : summary of one in-flight instruction held in the shadow pipeline
//   REG_PC      : index of the program counter register
//   fsm_state_t : issue controller state (normal run / one cycle after a taken branch)
package arm_pipe_pkg;

  typedef struct packed {
    logic       vld;
    logic       wb;
    logic [3:0] dest;
    logic       ld;
    logic       s;
  } inflight_t;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic {
    RUN     = 1'b0,
    FLUSHED = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/hazard_match.sv
// Compares the two source operands of the instruction in ID against one
// in-flight instruction and reports a read-after-write dependency.
//   src1, src1_used : first source index and its read enable
//   src2, src2_used : second source index and its read enable
//   entry           : in-flight instruction summary
//   hit             : entry is valid, writes a register, and that register is read
module hazard_match
  import arm_pipe_pkg::*;
(
  input  logic [3:0] src1,
  input  logic       src1_used,
  input  logic [3:0] src2,
  input  logic       src2_used,
  input  inflight_t  entry,
  output logic       hit
);

  // R15 is deliberately not special-cased: a pending PC write is a plain
  // register dependency for instructions that read R15.
  always_comb begin
    hit = entry.vld & entry.wb &
          ((src1_used & (src1 == entry.dest)) |
           (src2_used & (src2 == entry.dest)));
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue/hazard controller sitting in front of the ID/EXE pipeline register.
// A 3-entry shadow pipeline (E, M, W) mirrors the destinations of instructions
// in flight; stall/flush decisions are combinational from those entries.
//   clk, rst (active-low async)   : clock and reset
//   id_*                          : decoded fields of the instruction in ID
//   exe_B_taken                   : branch in EXE resolved taken
//   stall, flush_ifid, flush_idexe: pipeline control
//   issue                         : ID instruction enters EXE at the next edge
//   stall_cnt, flush_cnt          : saturating event counters
module id_issue_ctrl
  import arm_pipe_pkg::*;
#(
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_used,
  input  logic [3:0]       id_src2,
  input  logic             id_src2_used,
  input  logic [3:0]       id_dest,
  input  logic             id_WB_EN,
  input  logic             id_MEM_R_EN,
  input  logic             id_S,
  input  logic             id_cond_used,
  input  logic             exe_B_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idexe,
  output logic             issue,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  inflight_t  ent_e, ent_m, ent_w;
  fsm_state_t state;
  logic       hit_e, hit_m, hit_w;
  logic       valid_eff, taken_eff, raw_haz, st_haz;

  hazard_match u_match_e (
    .src1(id_src1), .src1_used(id_src1_used),
    .src2(id_src2), .src2_used(id_src2_used),
    .entry(ent_e), .hit(hit_e)
  );

  hazard_match u_match_m (
    .src1(id_src1), .src1_used(id_src1_used),
    .src2(id_src2), .src2_used(id_src2_used),
    .entry(ent_m), .hit(hit_m)
  );

  hazard_match u_match_w (
    .src1(id_src1), .src1_used(id_src1_used),
    .src2(id_src2), .src2_used(id_src2_used),
    .entry(ent_w), .hit(hit_w)
  );

  // In FLUSHED the instruction in ID is the wrong-path fetch that got past the
  // IF/ID flush one cycle late, so it is squashed; EXE holds a bubble, so a
  // taken indication then cannot be real either.
  always_comb begin
    valid_eff = id_valid & (state == RUN);
    taken_eff = exe_B_taken & (state == RUN);
    if (FWD_EN) raw_haz = hit_e & ent_e.ld;
    else        raw_haz = hit_e | hit_m | hit_w;
    st_haz      = id_cond_used & ent_e.vld & ent_e.s;
    stall       = valid_eff & ~taken_eff & (raw_haz | st_haz);
    issue       = valid_eff & ~stall & ~taken_eff;
    flush_ifid  = taken_eff;
    flush_idexe = taken_eff | stall;
  end

  // Shadow pipeline: always advances, E takes the issued instruction or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_e <= '0;
      ent_m <= '0;
      ent_w <= '0;
    end else begin
      ent_w <= ent_m;
      ent_m <= ent_e;
      if (issue) ent_e <= '{vld: 1'b1, wb: id_WB_EN, dest: id_dest, ld: id_MEM_R_EN, s: id_S};
      else       ent_e <= '0;
    end
  end

  // Branch-flush FSM together with the saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN: begin
          if (exe_B_taken) begin
            state <= FLUSHED;
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
          end
        end
        FLUSHED: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
